// File: rtl/sprite_position_ctrl.sv
// Sprite position controller: synchronises and debounces four push-buttons, then
// moves the sprite once per video frame with hold-to-accelerate and screen clamping.
module sprite_position_ctrl #(
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int SPRITE_SIZE     = 8,
  parameter int INIT_X          = 316,
  parameter int INIT_Y          = 236,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP            = 1,
  parameter int STEP_FAST       = 4,
  parameter int HOLD_FRAMES     = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_tick,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       pos_valid
);

  localparam int MAX_X  = SCREEN_W - 1 - SPRITE_SIZE;
  localparam int MAX_Y  = SCREEN_H - 1 - SPRITE_SIZE;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_e;

  logic [3:0]      btn_raw;
  logic [3:0]      meta_q, sync_q, stable_q;
  logic [DB_W-1:0] db_cnt_q [4];

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  // NOTE: every register below uses <= so all flops sample pre-edge values,
  // which is what makes the two-stage synchroniser an actual two-flop chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q   <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      meta_q <= btn_raw;
      sync_q <= meta_q;
      for (int i = 0; i < 4; i++) begin
        if (sync_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_q[i] <= ~stable_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  state_e              state_q;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_next;
  logic                tick_q, valid_q, update, active;
  logic [9:0]          pos_x_q, pos_y_q, pos_x_d, pos_y_d;
  logic signed [11:0]  dx, dy, step, sum_x, sum_y;

  function automatic logic [9:0] clamp(input logic signed [11:0] v, input int max_v);
    if (v < 0) return '0;
    if (int'(v) > max_v) return 10'(max_v);
    return 10'(v);
  endfunction

  assign update    = frame_tick & ~tick_q;
  assign active    = |stable_q;
  assign hold_next = hold_cnt_q + 1'b1;

  // Opposite buttons cancel; step size comes from the state before this frame's transition.
  always_comb begin
    dx = '0;
    dy = '0;
    case ({stable_q[BTN_RIGHT], stable_q[BTN_LEFT]})
      2'b10:   dx = 12'sd1;
      2'b01:   dx = -12'sd1;
      default: dx = '0;
    endcase
    case ({stable_q[BTN_DOWN], stable_q[BTN_UP]})
      2'b10:   dy = 12'sd1;
      2'b01:   dy = -12'sd1;
      default: dy = '0;
    endcase
    step    = (state_q == FAST) ? 12'(STEP_FAST) : 12'(STEP);
    sum_x   = $signed({2'b00, pos_x_q}) + dx * step;
    sum_y   = $signed({2'b00, pos_y_q}) + dy * step;
    pos_x_d = clamp(sum_x, MAX_X);
    pos_y_d = clamp(sum_y, MAX_Y);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      tick_q     <= 1'b0;
      valid_q    <= 1'b0;
      pos_x_q    <= 10'(INIT_X);
      pos_y_q    <= 10'(INIT_Y);
    end else begin
      tick_q  <= frame_tick;
      valid_q <= update;
      if (update) begin
        pos_x_q <= pos_x_d;
        pos_y_q <= pos_y_d;
        case (state_q)
          IDLE: begin
            if (active) begin
              state_q    <= SLOW;
              hold_cnt_q <= HOLD_W'(1);
            end
          end
          SLOW: begin
            if (!active) begin
              state_q    <= IDLE;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_next;
              if (hold_next == HOLD_W'(HOLD_FRAMES)) state_q <= FAST;
            end
          end
          FAST: begin
            if (!active) begin
              state_q    <= IDLE;
              hold_cnt_q <= '0;
            end
          end
          default: begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign pos_valid = valid_q;

endmodule

// File: tb/tb_sprite_position_ctrl.sv
// Scoreboarded bench for sprite_position_ctrl: stimulus pushes model expectations per
// frame tick, a negedge monitor pops and compares on every pos_valid pulse.
module tb_sprite_position_ctrl;

  localparam int INIT_X      = 316;
  localparam int INIT_Y      = 236;
  localparam int MAX_X       = 631;
  localparam int MAX_Y       = 471;
  localparam int HOLD_FRAMES = 30;
  localparam int STEP        = 1;
  localparam int STEP_FAST   = 4;
  localparam int FRAME       = 100;
  localparam int SETTLE      = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] btns = 4'b0000;  // {right, left, down, up}
  logic [9:0] pos_x, pos_y;
  logic       pos_valid;

  always #5 clock = ~clock;

  sprite_position_ctrl #(.DEBOUNCE_CYCLES(4)) u_dut (
    .clock      (clock),
    .reset      (reset),
    .btn_up     (btns[0]),
    .btn_down   (btns[1]),
    .btn_left   (btns[2]),
    .btn_right  (btns[3]),
    .frame_tick (frame_tick),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_valid  (pos_valid)
  );

  typedef struct {
    int x;
    int y;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   m_x      = INIT_X;
  int   m_y      = INIT_Y;
  int   m_hold   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Behavioural model: count consecutive held frames; frames beyond HOLD_FRAMES move fast.
  function automatic void model_tick();
    int dx, dy, step;
    dx = int'(btns[3]) - int'(btns[2]);
    dy = int'(btns[1]) - int'(btns[0]);
    if (btns == 4'b0000) m_hold = 0;
    else m_hold++;
    step = (m_hold > HOLD_FRAMES) ? STEP_FAST : STEP;
    m_x = clampi(m_x + dx * step, MAX_X);
    m_y = clampi(m_y + dy * step, MAX_Y);
  endfunction

  task automatic do_tick(input int len);
    repeat (SETTLE) @(negedge clock);
    model_tick();
    exp_q.push_back('{x: m_x, y: m_y, cyc: cyc + 1});
    frame_tick = 1'b1;
    repeat (len) @(negedge clock);
    frame_tick = 1'b0;
    repeat (3) @(negedge clock);
    check("valid_drained", exp_q.size(), 0);
    repeat (FRAME - SETTLE - len - 3) @(negedge clock);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1);
  endtask

  // Monitor: pops on every pos_valid, otherwise checks the outputs hold their last value.
  int   last_x = INIT_X;
  int   last_y = INIT_Y;
  exp_t e;
  always @(negedge clock) begin
    if (reset) begin
      last_x = INIT_X;
      last_y = INIT_Y;
    end else if (pos_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: pos_valid high with no pending update (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("pos_x", pos_x, e.x);
        check("pos_y", pos_y, e.y);
        check("valid_latency", cyc, e.cyc);
        last_x = e.x;
        last_y = e.y;
      end
    end else begin
      check("hold_x", pos_x, last_x);
      check("hold_y", pos_y, last_y);
    end
  end

  initial begin
    int b, w;
    #1 reset = 1'b1;
    #2;
    check("rst_pos_x", pos_x, INIT_X);
    check("rst_pos_y", pos_y, INIT_Y);
    check("rst_valid", pos_valid, 0);
    repeat (3) @(negedge clock);
    repeat (37) @(negedge clock);
    reset = 1'b0;

    ticks(3);

    // Short glitch must be filtered out.
    btns = 4'b1000;
    repeat (3) @(negedge clock);
    btns = 4'b0000;
    ticks(1);
    check("glitch_x", pos_x, 316);

    btns = 4'b1000;
    ticks(1);
    check("first_step_x", pos_x, 317);
    ticks(31);
    check("fast_x", pos_x, 354);

    btns = 4'b0000;
    ticks(1);
    btns = 4'b1000;
    ticks(1);
    check("reidle_x", pos_x, 355);

    btns = 4'b0100;
    ticks(120);
    check("clamp_left_x", pos_x, 0);

    btns = 4'b0000;
    ticks(1);
    btns = 4'b0010;
    ticks(90);
    check("clamp_down_y", pos_y, MAX_Y);

    btns = 4'b0000;
    ticks(1);
    btns = 4'b1100;
    ticks(40);
    check("cancel_x", pos_x, 0);
    check("cancel_y", pos_y, MAX_Y);
    btns = 4'b1101;
    ticks(1);
    check("cancel_fast_up_y", pos_y, MAX_Y - STEP_FAST);

    btns = 4'b0000;
    do_tick(5);

    btns = 4'b1010;
    ticks(35);
    repeat (40) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_x", pos_x, INIT_X);
    check("rst_mid_y", pos_y, INIT_Y);
    check("rst_mid_valid", pos_valid, 0);
    exp_q.delete();
    m_x = INIT_X;
    m_y = INIT_Y;
    m_hold = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    btns = 4'b1000;
    ticks(1);
    check("post_rst_x", pos_x, 317);
    check("post_rst_y", pos_y, INIT_Y);

    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 9) < 4) btns = 4'($urandom_range(0, 15));
      repeat (15) @(negedge clock);
      if ($urandom_range(0, 1) == 1) begin
        b = $urandom_range(0, 3);
        w = $urandom_range(1, 3);
        btns[b] = ~btns[b];
        repeat (w) @(negedge clock);
        btns[b] = ~btns[b];
      end
      do_tick($urandom_range(1, 4));
    end

    repeat (5) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
